// File: rtl/dctq_block_sched_if.sv
// dctq_block_sched_if: host, core and sink signals of the DCTQ ping-pong block scheduler.
// The master modport is the scheduler itself; the slave modport is its surroundings
// (host bank writer, DCTQ core and downstream sink).
interface dctq_block_sched_if #(
  parameter int CNT_W = 16
);
  // host side
  logic             sched_en;
  logic             load_done;
  logic             wr_bank;
  logic             buf_full;
  // core side
  logic             core_start;
  logic             core_bank;
  logic             core_ready;
  logic             core_valid;
  logic [5:0]       core_addr;
  logic             core_hold;
  // sink side and status
  logic             out_ready;
  logic             blk_done;
  logic [CNT_W-1:0] blk_count;
  logic             busy;
  logic             err_ovf;
  logic             err_proto;

  modport master (
    input  sched_en, load_done, core_ready, core_valid, core_addr, out_ready,
    output wr_bank, buf_full, core_start, core_bank, core_hold,
           blk_done, blk_count, busy, err_ovf, err_proto
  );

  modport slave (
    output sched_en, load_done, core_ready, core_valid, core_addr, out_ready,
    input  wr_bank, buf_full, core_start, core_bank, core_hold,
           blk_done, blk_count, busy, err_ovf, err_proto
  );
endinterface

// File: rtl/dctq_block_sched.sv
// dctq_block_sched: ping-pong block scheduler in front of the DCTQ core.
// Tracks the fill state of two 8x8 input banks, starts the core on each full bank,
// counts the BLK_COEFS coefficients it emits and releases the bank afterwards.
// Optional feature macro: DCTQ_SCHED_ADDRCHK_EN - when defined, every accepted
// coefficient's core_addr is checked against the running coefficient counter.
// The CNT_W parameter must match the CNT_W of the connected interface instance.
module dctq_block_sched #(
  parameter int BLK_COEFS = 64,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  dctq_block_sched_if.master   bus
);

  localparam int           CW   = (BLK_COEFS > 1) ? $clog2(BLK_COEFS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLK_COEFS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             core_start_r;
  logic             busy_r;
  logic [CNT_W-1:0] blk_count_r;
  logic             err_proto_r;
  logic             err_ovf_r;
  logic [1:0]       full_r;
  logic             wr_ptr_r;
  logic             rd_ptr_r;

  logic             hold_s;
  logic             accept_s;
  logic             last_s;
  logic             stray_s;
  logic             addr_err_s;
  logic [1:0]       full_rel_s;
  logic [1:0]       full_nxt_s;
  logic             load_ok_s;
  logic             load_ovf_s;

`ifndef DCTQ_SCHED_ADDRCHK_EN
  // core_addr only matters when the address check is built in
  logic             unused_addr_s;
  assign unused_addr_s = ^bus.core_addr;
`endif

  // Beat qualification, bank release/load arbitration and error detection
  always_comb begin
    hold_s     = (state_r == RUN) && !bus.out_ready;
    accept_s   = (state_r == RUN) && bus.core_valid && !hold_s;
    last_s     = accept_s && (cnt_r == LAST);
    stray_s    = bus.core_valid && (state_r != RUN);
    addr_err_s = 1'b0;
`ifdef DCTQ_SCHED_ADDRCHK_EN
    if (accept_s && (bus.core_addr != 6'(cnt_r))) begin
      addr_err_s = 1'b1;
    end else begin
      addr_err_s = 1'b0;
    end
`endif
    // release is applied first so a load on a fully occupied buffer lands in the freed bank
    full_rel_s = full_r;
    if (last_s) begin
      full_rel_s[rd_ptr_r] = 1'b0;
    end else begin
      full_rel_s = full_r;
    end
    load_ok_s  = bus.load_done && !(&full_rel_s);
    load_ovf_s = bus.load_done && (&full_rel_s);
    full_nxt_s = full_rel_s;
    if (load_ok_s) begin
      full_nxt_s[wr_ptr_r] = 1'b1;
    end else begin
      full_nxt_s = full_rel_s;
    end
  end

  // Scheduler FSM: start the core on a full bank, wait for it to go busy, count its beats
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      blk_count_r  <= '0;
      err_proto_r  <= 1'b0;
    end else begin
      core_start_r <= 1'b0;
      if (stray_s || addr_err_s) begin
        err_proto_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (bus.sched_en && full_r[rd_ptr_r] && bus.core_ready) begin
            state_r      <= START;
            core_start_r <= 1'b1;
            busy_r       <= 1'b1;
          end
        end
        START: begin
          state_r <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.core_ready) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (last_s) begin
            cnt_r       <= '0;
            blk_count_r <= blk_count_r + CNT_W'(1);
            state_r     <= IDLE;
            busy_r      <= 1'b0;
          end else if (accept_s) begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Bank fill flags, write/read pointers and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r    <= 2'b00;
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      err_ovf_r <= 1'b0;
    end else begin
      full_r <= full_nxt_s;
      if (load_ok_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (last_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      if (load_ovf_s) begin
        err_ovf_r <= 1'b1;
      end
    end
  end

  assign bus.wr_bank    = wr_ptr_r;
  assign bus.core_bank  = rd_ptr_r;
  assign bus.buf_full   = &full_r;
  assign bus.core_start = core_start_r;
  assign bus.core_hold  = hold_s;
  assign bus.blk_done   = last_s;
  assign bus.blk_count  = blk_count_r;
  assign bus.busy       = busy_r;
  assign bus.err_ovf    = err_ovf_r;
  assign bus.err_proto  = err_proto_r;

endmodule

// File: tb/tb_dctq_block_sched.sv
// tb_dctq_block_sched: directed bench for the DCTQ ping-pong block scheduler.
// Inputs change 1 time unit after the rising edge; outputs are compared 3 units after it.
module tb_dctq_block_sched;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  dctq_block_sched_if #(.CNT_W(16)) bus ();

  dctq_block_sched #(.BLK_COEFS(64), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.sched_en   = 1'b0;
    bus.load_done  = 1'b0;
    bus.core_ready = 1'b1;
    bus.core_valid = 1'b0;
    bus.core_addr  = 6'd0;
    bus.out_ready  = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic load_pulse();
    bus.load_done = 1'b1;
    cyc();
    bus.load_done = 1'b0;
  endtask

  // Waits (bounded) for core_start and checks the bank the core will read
  task automatic wait_start(input logic exp_bank);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (bus.core_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL start_timeout got=no core_start exp=core_start within 20 cycles"); end
    checks++;
    if (bus.core_bank !== exp_bank) begin failures++; $display("FAIL start_bank got=%b exp=%b", bus.core_bank, exp_bank); end
  endtask

  // Core model: entered in the core_start cycle; drops ready, emits 64 beats.
  // Cycles k in [hold_at, hold_at+hold_len) have out_ready low; beat bad_beat carries addr 5.
  task automatic run_block(input int hold_at, input int hold_len, input int bad_beat, input bit load_on_last);
    int   beat;
    int   k;
    int   held;
    logic ordy;
    logic exp_done;
    beat = 0; k = 0; held = 0;
    cyc();
    bus.core_ready = 1'b0;
    cyc();
    while (beat < 64 && k < 300) begin
      ordy           = !(k >= hold_at && k < hold_at + hold_len);
      bus.core_valid = 1'b1;
      bus.core_addr  = (beat == bad_beat) ? 6'd5 : 6'(beat);
      bus.out_ready  = ordy;
      bus.load_done  = load_on_last && (beat == 63) && ordy;
      #2;
      if (!ordy) begin
        held++;
        checks++;
        if (bus.core_hold !== 1'b1) begin failures++; $display("FAIL hold_on k=%0d got=%b exp=1", k, bus.core_hold); end
        checks++;
        if (bus.blk_done !== 1'b0) begin failures++; $display("FAIL done_in_hold k=%0d got=%b exp=0", k, bus.blk_done); end
      end else begin
        exp_done = (beat == 63);
        checks++;
        if (bus.core_hold !== 1'b0) begin failures++; $display("FAIL hold_off beat=%0d got=%b exp=0", beat, bus.core_hold); end
        checks++;
        if (bus.blk_done !== exp_done) begin failures++; $display("FAIL blk_done beat=%0d got=%b exp=%b", beat, bus.blk_done, exp_done); end
        beat++;
      end
      cyc();
      k++;
    end
    bus.core_valid = 1'b0;
    bus.load_done  = 1'b0;
    bus.out_ready  = 1'b1;
    checks++;
    if (beat != 64) begin failures++; $display("FAIL block_timeout got=%0d beats exp=64", beat); end
    checks++;
    if (held != hold_len) begin failures++; $display("FAIL hold_cycles got=%0d exp=%0d", held, hold_len); end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.sched_en  = 1'b1;
    bus.load_done = 1'b1;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    #2;
    checks++; if (bus.wr_bank    !== 1'b0)  begin failures++; $display("FAIL rst_wr_bank got=%b exp=0", bus.wr_bank); end
    checks++; if (bus.buf_full   !== 1'b0)  begin failures++; $display("FAIL rst_buf_full got=%b exp=0", bus.buf_full); end
    checks++; if (bus.core_start !== 1'b0)  begin failures++; $display("FAIL rst_core_start got=%b exp=0", bus.core_start); end
    checks++; if (bus.core_bank  !== 1'b0)  begin failures++; $display("FAIL rst_core_bank got=%b exp=0", bus.core_bank); end
    checks++; if (bus.core_hold  !== 1'b0)  begin failures++; $display("FAIL rst_core_hold got=%b exp=0", bus.core_hold); end
    checks++; if (bus.blk_done   !== 1'b0)  begin failures++; $display("FAIL rst_blk_done got=%b exp=0", bus.blk_done); end
    checks++; if (bus.blk_count  !== 16'd0) begin failures++; $display("FAIL rst_blk_count got=%0d exp=0", bus.blk_count); end
    checks++; if (bus.busy       !== 1'b0)  begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.err_ovf    !== 1'b0)  begin failures++; $display("FAIL rst_err_ovf got=%b exp=0", bus.err_ovf); end
    checks++; if (bus.err_proto  !== 1'b0)  begin failures++; $display("FAIL rst_err_proto got=%b exp=0", bus.err_proto); end
    cyc();
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_block();
    do_reset();
    bus.sched_en = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    load_pulse();                       // load_done in cycle t, now in t+1
    #2;
    checks++; if (bus.core_start !== 1'b0) begin failures++; $display("FAIL lat_t1_start got=%b exp=0", bus.core_start); end
    cyc();                              // cycle t+2
    #2;
    checks++; if (bus.core_start !== 1'b1) begin failures++; $display("FAIL lat_t2_start got=%b exp=1", bus.core_start); end
    checks++; if (bus.core_bank  !== 1'b0) begin failures++; $display("FAIL single_bank got=%b exp=0", bus.core_bank); end
    checks++; if (bus.busy       !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.wr_bank    !== 1'b1) begin failures++; $display("FAIL single_wr_bank_mid got=%b exp=1", bus.wr_bank); end
    run_block(1000, 0, -1, 1'b0);
    #2;
    checks++; if (bus.blk_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.blk_count); end
    checks++; if (bus.wr_bank   !== 1'b1)  begin failures++; $display("FAIL single_wr_bank got=%b exp=1", bus.wr_bank); end
    checks++; if (bus.core_bank !== 1'b1)  begin failures++; $display("FAIL single_rd_bank got=%b exp=1", bus.core_bank); end
    checks++; if (bus.busy      !== 1'b0)  begin failures++; $display("FAIL single_idle got=%b exp=0", bus.busy); end
    checks++; if (bus.err_proto !== 1'b0)  begin failures++; $display("FAIL single_err_proto got=%b exp=0", bus.err_proto); end
    cyc();
  endtask

  task automatic test_pingpong_ovf();
    do_reset();
    bus.sched_en   = 1'b1;
    bus.core_ready = 1'b0;
    load_pulse();
    load_pulse();
    #2;
    checks++; if (bus.buf_full !== 1'b1) begin failures++; $display("FAIL pp_full got=%b exp=1", bus.buf_full); end
    checks++; if (bus.wr_bank  !== 1'b0) begin failures++; $display("FAIL pp_wr_bank got=%b exp=0", bus.wr_bank); end
    checks++; if (bus.err_ovf  !== 1'b0) begin failures++; $display("FAIL pp_no_ovf got=%b exp=0", bus.err_ovf); end
    cyc();
    load_pulse();
    #2;
    checks++; if (bus.err_ovf  !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.err_ovf); end
    checks++; if (bus.buf_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", bus.buf_full); end
    checks++; if (bus.wr_bank  !== 1'b0) begin failures++; $display("FAIL ovf_wr_bank got=%b exp=0", bus.wr_bank); end
    cyc();
    bus.core_ready = 1'b1;
    wait_start(1'b0);
    bus.sched_en = 1'b0;                // must not abort the block in flight
    run_block(1000, 0, -1, 1'b0);
    #2;
    checks++; if (bus.blk_count !== 16'd1) begin failures++; $display("FAIL pp_count got=%0d exp=1", bus.blk_count); end
    checks++; if (bus.buf_full  !== 1'b0)  begin failures++; $display("FAIL pp_freed got=%b exp=0", bus.buf_full); end
    checks++; if (bus.err_ovf   !== 1'b1)  begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.err_ovf); end
    cyc();
    bus.core_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (bus.core_start !== 1'b0) begin failures++; $display("FAIL en_low_start i=%0d got=%b exp=0", i, bus.core_start); end
      cyc();
    end
    load_pulse();
    #2;
    checks++; if (bus.buf_full !== 1'b1) begin failures++; $display("FAIL pp_reload_full got=%b exp=1", bus.buf_full); end
    checks++; if (bus.wr_bank  !== 1'b1) begin failures++; $display("FAIL pp_reload_wr got=%b exp=1", bus.wr_bank); end
    cyc();
  endtask

  task automatic test_back_pressure();
    do_reset();
    bus.sched_en = 1'b1;
    load_pulse();
    wait_start(1'b0);
    run_block(20, 5, -1, 1'b0);
    #2;
    checks++; if (bus.blk_count !== 16'd1) begin failures++; $display("FAIL bp_count got=%0d exp=1", bus.blk_count); end
    cyc();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.sched_en  = 1'b1;
    bus.load_done = 1'b1;
    cyc();                              // second consecutive load
    cyc();
    bus.load_done = 1'b0;
    #2;
    checks++; if (bus.core_start !== 1'b1) begin failures++; $display("FAIL b2b_start got=%b exp=1", bus.core_start); end
    checks++; if (bus.buf_full   !== 1'b1) begin failures++; $display("FAIL b2b_full got=%b exp=1", bus.buf_full); end
    run_block(1000, 0, -1, 1'b1);       // load coincides with the release of bank 0
    #2;
    checks++; if (bus.buf_full  !== 1'b1) begin failures++; $display("FAIL simul_full got=%b exp=1", bus.buf_full); end
    checks++; if (bus.err_ovf   !== 1'b0) begin failures++; $display("FAIL simul_ovf got=%b exp=0", bus.err_ovf); end
    checks++; if (bus.wr_bank   !== 1'b1) begin failures++; $display("FAIL simul_wr got=%b exp=1", bus.wr_bank); end
    checks++; if (bus.core_bank !== 1'b1) begin failures++; $display("FAIL simul_rd got=%b exp=1", bus.core_bank); end
    cyc();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (bus.core_start !== 1'b0) begin failures++; $display("FAIL b2b_not_ready i=%0d got=%b exp=0", i, bus.core_start); end
      cyc();
    end
    bus.core_ready = 1'b1;
    wait_start(1'b1);
    run_block(1000, 0, -1, 1'b0);
    #2;
    checks++; if (bus.blk_count !== 16'd2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", bus.blk_count); end
    checks++; if (bus.buf_full  !== 1'b0)  begin failures++; $display("FAIL b2b_full_end got=%b exp=0", bus.buf_full); end
    checks++; if (bus.core_bank !== 1'b0)  begin failures++; $display("FAIL b2b_rd_end got=%b exp=0", bus.core_bank); end
    cyc();
  endtask

  // Runs right after test_back_to_back: bank 0 is still full and blk_count is 2
  task automatic test_reset_mid_block();
    bus.core_ready = 1'b1;
    wait_start(1'b0);
    cyc();
    bus.core_ready = 1'b0;
    cyc();
    for (int b = 0; b < 30; b++) begin
      bus.core_valid = 1'b1;
      bus.core_addr  = 6'(b);
      cyc();
    end
    reset          = 1'b1;
    bus.out_ready  = 1'b0;
    cyc();
    #2;
    checks++; if (bus.blk_count !== 16'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", bus.blk_count); end
    checks++; if (bus.busy      !== 1'b0)  begin failures++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.buf_full  !== 1'b0)  begin failures++; $display("FAIL mid_full got=%b exp=0", bus.buf_full); end
    checks++; if (bus.wr_bank   !== 1'b0)  begin failures++; $display("FAIL mid_wr got=%b exp=0", bus.wr_bank); end
    checks++; if (bus.core_hold !== 1'b0)  begin failures++; $display("FAIL mid_hold got=%b exp=0", bus.core_hold); end
    checks++; if (bus.blk_done  !== 1'b0)  begin failures++; $display("FAIL mid_done got=%b exp=0", bus.blk_done); end
    cyc();
    reset = 1'b0;
    idle_inputs();
    bus.sched_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if (bus.core_start !== 1'b0) begin failures++; $display("FAIL mid_empty_start i=%0d got=%b exp=0", i, bus.core_start); end
      cyc();
    end
    load_pulse();
    cyc();
    #2;
    checks++; if (bus.core_start !== 1'b1) begin failures++; $display("FAIL mid_fresh_start got=%b exp=1", bus.core_start); end
    checks++; if (bus.core_bank  !== 1'b0) begin failures++; $display("FAIL mid_fresh_bank got=%b exp=0", bus.core_bank); end
    run_block(1000, 0, -1, 1'b0);
    #2;
    checks++; if (bus.blk_count !== 16'd1) begin failures++; $display("FAIL mid_fresh_count got=%0d exp=1", bus.blk_count); end
    cyc();
  endtask

  task automatic test_stray_valid();
    do_reset();
    bus.core_valid = 1'b1;              // beat while IDLE
    cyc();
    bus.core_valid = 1'b0;
    #2;
    checks++; if (bus.err_proto !== 1'b1) begin failures++; $display("FAIL stray_err got=%b exp=1", bus.err_proto); end
    cyc();
    bus.sched_en = 1'b1;
    load_pulse();
    wait_start(1'b0);
    run_block(1000, 0, -1, 1'b0);       // stray beat must not have advanced the counter
    #2;
    checks++; if (bus.blk_count !== 16'd1) begin failures++; $display("FAIL stray_count got=%0d exp=1", bus.blk_count); end
    cyc();
  endtask

  task automatic test_addr_check();
    logic exp_err;
`ifdef DCTQ_SCHED_ADDRCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    bus.sched_en = 1'b1;
    load_pulse();
    wait_start(1'b0);
    run_block(1000, 0, 4, 1'b0);
    #2;
    checks++; if (bus.err_proto !== exp_err) begin failures++; $display("FAIL addr_err got=%b exp=%b", bus.err_proto, exp_err); end
    checks++; if (bus.blk_count !== 16'd1)   begin failures++; $display("FAIL addr_count got=%0d exp=1", bus.blk_count); end
    cyc();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_single_block();
    test_pingpong_ovf();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_block();
    test_stray_valid();
    test_addr_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
